// File: rtl/digit_scan_driver_pkg.sv
// Shared types and width helpers for the multiplexed-display digit scanner.
package digit_scan_pkg;

    // Scanner FSM: BLANK keeps every digit dark, DRIVE lights exactly one digit.
    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } scan_state_t;

    // Width of a digit index for n digits (n is always at least 2).
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Width of a down-counter that must hold values 0..max_val.
    function automatic int cnt_width(input longint unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/digit_scan_driver_if.sv
// Control inputs and display outputs of the digit scanner.
// There is no valid/ready handshake: en, dir and digit_mask are level controls
// sampled on every rising clock edge; anode, digit_idx, blank, tick and state
// are registered and valid in every cycle.
interface digit_scan_driver_if
    import digit_scan_pkg::*;
#(
    parameter int NUM_DIGITS = 4
);
    localparam int IW = idx_width(NUM_DIGITS);

    logic                  en;
    logic                  dir;
    logic [NUM_DIGITS-1:0] digit_mask;
    logic [NUM_DIGITS-1:0] anode;
    logic [IW-1:0]         digit_idx;
    logic                  blank;
    logic                  tick;
    scan_state_t           state;

    modport master (
        output en, dir, digit_mask,
        input  anode, digit_idx, blank, tick, state
    );

    modport slave (
        input  en, dir, digit_mask,
        output anode, digit_idx, blank, tick, state
    );
endinterface

// File: rtl/digit_scan_driver_scan_next_sel.sv
// Next-digit picker: walks the rotation away from the current index and
// returns the first enabled digit. The walk visits all positions and, unless
// inclusive is set, ends on the current index so a lone digit repeats.
module scan_next_sel
    import digit_scan_pkg::*;
#(
    parameter  int NUM_DIGITS = 4,
    localparam int IW         = idx_width(NUM_DIGITS)
) (
    input  logic [IW-1:0]         cur_idx,
    input  logic                  dir,
    input  logic [NUM_DIGITS-1:0] mask,
    input  logic                  inclusive,
    output logic [IW-1:0]         next_idx,
    output logic                  valid
);

    // Scan from the farthest offset back to the nearest so the nearest hit wins.
    always_comb begin
        int off;
        int pos;
        next_idx = '0;
        valid    = 1'b0;
        off      = 0;
        pos      = 0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            off = inclusive ? k : k + 1;
            if (dir)
                pos = (int'(cur_idx) + NUM_DIGITS - off) % NUM_DIGITS;
            else
                pos = (int'(cur_idx) + off) % NUM_DIGITS;
            if (mask[pos]) begin
                next_idx = IW'(pos);
                valid    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/digit_scan_driver.sv
// Multiplexed-display digit scanner: one digit enable at a time, each held for
// DWELL_CYCLES and separated by BLANK_CYCLES of all-dark anti-ghosting gap.
module digit_scan_driver
    import digit_scan_pkg::*;
#(
    parameter int          NUM_DIGITS   = 4,
    parameter int unsigned DWELL_CYCLES = 32'h0126_0000,
    parameter int unsigned BLANK_CYCLES = 16,
    parameter bit          ACTIVE_LOW   = 1'b1
) (
    input logic                clk,
    input logic                reset,
    digit_scan_driver_if.slave bus
);

    localparam int          IW      = idx_width(NUM_DIGITS);
    localparam int unsigned MAX_CNT = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int          TW      = cnt_width(longint'(MAX_CNT));

    localparam logic [TW-1:0] DWELL_LOAD = TW'(DWELL_CYCLES - 1);
    localparam logic [TW-1:0] BLANK_LOAD = TW'(BLANK_CYCLES - 1);

    scan_state_t           state_q, state_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic                  first_q, first_d;
    logic [NUM_DIGITS-1:0] anode_q, anode_d;
    logic                  tick_q, tick_d;

    logic [IW-1:0]         sel_idx;
    logic                  sel_valid;

    // First selection after reset searches inclusively so digit 0 leads.
    scan_next_sel #(
        .NUM_DIGITS (NUM_DIGITS)
    ) u_next_sel (
        .cur_idx   (idx_q),
        .dir       (bus.dir),
        .mask      (bus.digit_mask),
        .inclusive (first_q),
        .next_idx  (sel_idx),
        .valid     (sel_valid)
    );

    // Next-state, timer and registered-output values.
    always_comb begin
        logic act;
        state_d = state_q;
        timer_d = timer_q;
        idx_d   = idx_q;
        first_d = first_q;
        tick_d  = 1'b0;
        act     = 1'b0;

        case (state_q)
            ST_BLANK: begin
                if (bus.en) begin
                    if (timer_q == '0) begin
                        if (sel_valid) begin
                            state_d = ST_DRIVE;
                            timer_d = DWELL_LOAD;
                            idx_d   = sel_idx;
                            first_d = 1'b0;
                            tick_d  = 1'b1;
                        end else begin
                            timer_d = BLANK_LOAD;
                        end
                    end else begin
                        timer_d = timer_q - TW'(1);
                    end
                end
            end
            ST_DRIVE: begin
                // Disable, a cleared mask bit or an expired dwell all end the digit.
                if (!bus.en || !bus.digit_mask[idx_q] || timer_q == '0) begin
                    state_d = ST_BLANK;
                    timer_d = BLANK_LOAD;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            default: begin
                state_d = ST_BLANK;
                timer_d = BLANK_LOAD;
            end
        endcase

        for (int i = 0; i < NUM_DIGITS; i++) begin
            act        = (state_d == ST_DRIVE) && (idx_d == IW'(i));
            anode_d[i] = ACTIVE_LOW ? !act : act;
        end
    end

    // State, timer and output registers; reset overrides everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_BLANK;
            timer_q <= BLANK_LOAD;
            idx_q   <= '0;
            first_q <= 1'b1;
            anode_q <= ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            idx_q   <= idx_d;
            first_q <= first_d;
            anode_q <= anode_d;
            tick_q  <= tick_d;
        end
    end

    assign bus.anode     = anode_q;
    assign bus.digit_idx = idx_q;
    assign bus.blank     = (state_q == ST_BLANK);
    assign bus.tick      = tick_q;
    assign bus.state     = state_q;

endmodule

// File: tb/tb_digit_scan_driver.sv
// Bench for digit_scan_driver with NUM_DIGITS=4, DWELL=5, BLANK=2, active-low.
// Expected outputs come from a timeline model (lead gap, then fixed-period slots
// cycling through an expected digit order) and flow through a scoreboard queue.
module tb_digit_scan_driver;
    import digit_scan_pkg::*;

    localparam int ND = 4;
    localparam int DW = 5;
    localparam int BL = 2;
    localparam int PER = DW + BL;

    logic clk;
    logic reset;

    digit_scan_driver_if #(.NUM_DIGITS(ND)) bus ();

    digit_scan_driver #(
        .NUM_DIGITS   (ND),
        .DWELL_CYCLES (DW),
        .BLANK_CYCLES (BL),
        .ACTIVE_LOW   (1'b1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Clock and initial input levels.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        reset          = 1'b1;
        bus.en         = 1'b0;
        bus.dir        = 1'b0;
        bus.digit_mask = 4'b1111;
    end

    // Scoreboard: bit 8 = compare this cycle, bits 7:0 = {anode, blank, tick, idx}.
    logic [8:0] exp_q[$];
    int         n_checks = 0;
    int         n_pass   = 0;
    string      phase    = "init";

    // Monitor: compare one queued expectation per cycle, away from the edge.
    always @(negedge clk) begin
        logic [8:0] e;
        logic [7:0] act;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            act = {bus.anode, bus.blank, bus.tick, bus.digit_idx};
            if (e[8]) begin
                n_checks++;
                if (act === e[7:0]) n_pass++;
                else
                    $display("FAIL %s t=%0t: got anode=%b blank=%b tick=%b idx=%0d, want anode=%b blank=%b tick=%b idx=%0d",
                             phase, $time, act[7:4], act[3], act[2], act[1:0],
                             e[7:4], e[3], e[2], e[1:0]);
            end
        end
    end

    // Drive one cycle of inputs and queue the outputs expected in that cycle.
    task automatic step(input logic rst_i, input logic en_i, input logic dir_i,
                        input logic [3:0] mask_i, input logic chk, input logic [7:0] exp_w);
        @(posedge clk);
        #1;
        reset          = rst_i;
        bus.en         = en_i;
        bus.dir        = dir_i;
        bus.digit_mask = mask_i;
        exp_q.push_back({chk, exp_w});
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, 4'b1111, 1'b0, 8'h00);
        step(1'b1, 1'b0, 1'b0, 4'b1111, 1'b0, 8'h00);
    endtask

    // Timeline model: 'lead' dark cycles, then slots of DW lit + BL dark cycles
    // cycling through k digits stored two bits each in ord.
    function automatic logic [7:0] exp_word(input int lead, input int k, input logic [7:0] ord,
                                            input int prev, input int t);
        int u, slot, ph;
        logic [1:0] d;
        logic [3:0] an;
        u = t - lead;
        if (u < 0) return {4'b1111, 1'b1, 1'b0, 2'(prev)};
        slot = u / PER;
        ph   = u % PER;
        d    = ord[(slot % k) * 2 +: 2];
        if (ph < DW) begin
            an = 4'b1111 & ~(4'b0001 << d);
            return {an, 1'b0, (ph == 0), d};
        end
        return {4'b1111, 1'b1, 1'b0, d};
    endfunction

    task automatic run_scan(input logic rst_i, input logic en_i, input logic dir_i,
                            input logic [3:0] mask_i, input int lead, input int k,
                            input logic [7:0] ord, input int prev,
                            input int t_from, input int t_to);
        for (int t = t_from; t <= t_to; t++)
            step(rst_i, en_i, dir_i, mask_i, 1'b1, exp_word(lead, k, ord, prev, t));
    endtask

    typedef struct {
        string      name;
        logic       dir;
        logic [3:0] mask;
        int         k;
        logic [7:0] ord;
        int         ncyc;
    } scen_t;

    scen_t scen[3];

    // Stimulus sequence.
    initial begin
        // Digit orders packed two bits per slot, slot 0 in bits 1:0.
        scen[0] = '{"ascending",  1'b0, 4'b1111, 4, 8'b11_10_01_00, 60};
        scen[1] = '{"descending", 1'b1, 4'b1111, 4, 8'b01_10_11_00, 60};
        scen[2] = '{"sparse",     1'b0, 4'b0101, 2, 8'b00_00_10_00, 40};

        for (int s = 0; s < 3; s++) begin
            do_reset();
            phase = scen[s].name;
            run_scan(1'b0, 1'b1, scen[s].dir, scen[s].mask, BL, scen[s].k, scen[s].ord,
                     0, 0, scen[s].ncyc - 1);
        end

        // Empty mask keeps everything dark, then a lone digit repeats.
        do_reset();
        phase = "empty_mask";
        run_scan(1'b0, 1'b1, 1'b0, 4'b0000, 1000, 1, 8'h00, 0, 0, 9);
        phase = "single_digit";
        run_scan(1'b0, 1'b1, 1'b0, 4'b0010, BL, 1, 8'b00_00_00_01, 0, 0, 21);

        // Enable drop on the 3rd lit cycle of digit 1, hold, re-enable.
        do_reset();
        phase = "en_drop_pre";
        run_scan(1'b0, 1'b1, 1'b0, 4'b1111, BL, 4, 8'b11_10_01_00, 0, 0, 10);
        run_scan(1'b0, 1'b0, 1'b0, 4'b1111, BL, 4, 8'b11_10_01_00, 0, 11, 11);
        phase = "en_low";
        run_scan(1'b0, 1'b0, 1'b0, 4'b1111, 1000, 1, 8'h00, 1, 0, 3);
        phase = "en_resume";
        run_scan(1'b0, 1'b1, 1'b0, 4'b1111, BL, 4, 8'b01_00_11_10, 1, 0, 24);

        // Reset asserted while digit 2 is lit.
        do_reset();
        phase = "reset_mid_pre";
        run_scan(1'b0, 1'b1, 1'b0, 4'b1111, BL, 4, 8'b11_10_01_00, 0, 0, 17);
        run_scan(1'b1, 1'b1, 1'b0, 4'b1111, BL, 4, 8'b11_10_01_00, 0, 18, 18);
        phase = "reset_mid_post";
        run_scan(1'b0, 1'b1, 1'b0, 4'b1111, BL, 4, 8'b11_10_01_00, 0, 0, 15);

        // Clear digit 1's mask bit on its 2nd lit cycle.
        do_reset();
        phase = "mask_clr_pre";
        run_scan(1'b0, 1'b1, 1'b0, 4'b1111, BL, 4, 8'b11_10_01_00, 0, 0, 9);
        run_scan(1'b0, 1'b1, 1'b0, 4'b1101, BL, 4, 8'b11_10_01_00, 0, 10, 10);
        phase = "mask_clr_post";
        run_scan(1'b0, 1'b1, 1'b0, 4'b1101, BL, 3, 8'b00_00_11_10, 1, 0, 25);

        @(negedge clk);
        @(negedge clk);
        phase = "drain";
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain: got %0d entries left, want 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/digit_scan_driver.md
# digit_scan_driver

Parametrised multiplexed-display digit scanner: rotates a single active digit-enable across `NUM_DIGITS` outputs. Each digit is held for a programmable dwell time, and a programmable blanking gap separates consecutive digits to suppress ghosting. Runtime controls set scan direction, a per-digit skip mask and a global enable. It sits between the system clock and the display anode/segment mux and supersedes the fixed 4-digit, fixed-period scan counter.

## Interface
- `NUM_DIGITS`, 4: number of digit-enable outputs; legal range 2..16.
- `DWELL_CYCLES`, 32'h0126_0000: clock cycles each digit is driven; must be ≥ 1.
- `BLANK_CYCLES`, 16: clock cycles with all digits off between digits; must be ≥ 1.
- `ACTIVE_LOW`, 1: 1 = an active digit output is 0 and inactive is 1; 0 = inverted polarity.

Ports:
- `clk` input 1: single clock. All logic is on its rising edge.
- `reset` input 1: synchronous, active-high reset.
- `en` input 1: scan enable.
- `dir` input 1: 0 = ascending index, 1 = descending index. Sampled at each digit selection.
- `digit_mask` input NUM_DIGITS: bit i = 1 allows digit i to be scanned.
- `anode` output NUM_DIGITS: registered digit enables; at most one is active.
- `digit_idx` output clog2(NUM_DIGITS): index of the current or most recent digit. Used by the segment mux.
- `blank` output 1: 1 when no digit is active.
- `tick` output 1: one-cycle pulse in the first cycle a new digit is active.

## Operation
- **FSM states:** BLANK and DRIVE. A down-counting timer is sized to clog2(max(DWELL_CYCLES, BLANK_CYCLES) + 1) bits.
- **Reset values:**
  - state = BLANK, timer = BLANK_CYCLES − 1, `digit_idx` = 0, first-select flag = 1.
  - `anode` = all inactive, `blank` = 1, `tick` = 0.
- **BLANK state:**
  - The timer decrements each cycle while `en` = 1.
  - At timer = 0, the next digit is selected. If one is found: `digit_idx` ← selected, state ← DRIVE, timer ← DWELL_CYCLES − 1, `tick` = 1 for that cycle. The first-select flag then clears.
  - If no digit is selectable, the FSM stays in BLANK and the timer reloads to BLANK_CYCLES − 1.
- **Digit selection:**
  - Search the rotation from `digit_idx` + 1 (`dir` = 0) or `digit_idx` − 1 (`dir` = 1), modulo NUM_DIGITS.
  - The search covers all NUM_DIGITS positions and ends at `digit_idx` itself, so a single enabled digit repeats.
  - When the first-select flag is set, the search starts at `digit_idx` inclusive, so digit 0 comes first after reset.
- **DRIVE state:**
  - `anode[digit_idx]` is active. The timer decrements each cycle.
  - At timer = 0: state ← BLANK, timer ← BLANK_CYCLES − 1.
- **Mask cleared mid-DRIVE:** if `digit_mask[digit_idx]` is 0 in DRIVE, the next cycle goes to BLANK with timer ← BLANK_CYCLES − 1, anodes off.
- **Enable low:**
  - `en` = 0 in DRIVE: the next cycle goes to BLANK with the timer reloaded.
  - `en` = 0 in BLANK: the timer is frozen.
  - `digit_idx` is retained. After re-enable, a full blank gap precedes the next digit.
- **Outputs:**
  - `blank` = 1 exactly when state = BLANK.
  - `anode` is one-hot in DRIVE (all-active-hot, polarity per ACTIVE_LOW) and all inactive in BLANK.
- **Reset precedence:** `reset` overrides every other input, including in mid-DRIVE.

## Timing
- All outputs are registered; none has a combinational path from any input.
- With all digits enabled, each digit is active for exactly DWELL_CYCLES consecutive cycles, separated by exactly BLANK_CYCLES inactive cycles.
- Scan period = k × (DWELL_CYCLES + BLANK_CYCLES) for k enabled digits.
- Timing from the first cycle with `reset` = 0 and `en` = 1:
  - The first BLANK_CYCLES cycles are blank.
  - `anode[0]` is active in cycle BLANK_CYCLES, with `tick` high in that cycle.
- `dir` and `digit_mask` changes take effect at the next selection, except the mid-DRIVE mask clear, which takes effect one cycle later.
- The index wraps NUM_DIGITS−1 → 0 (ascending) and 0 → NUM_DIGITS−1 (descending) with no extra cycles.

## Structure
- **Package `digit_scan_pkg`:** holds the state enum (BLANK, DRIVE) and a `clog2`-based width function for the timer and index.
- **Sub-module `scan_next_sel`:** combinational. Inputs: current index, `dir`, mask, inclusive flag. Outputs: next index and a valid bit. It is a rotate-then-priority-encode, instantiated once.
- **Top level:** FSM, timer and output registers.

## Test plan
All scenarios use NUM_DIGITS=4, DWELL_CYCLES=5, BLANK_CYCLES=2, ACTIVE_LOW=1.
- **Ascending scan:** reset, then `en`=1, `mask`=1111, `dir`=0 → `anode` sequence 1111×2, 1110×5, 1111×2, 1101×5, 1111×2, 1011×5, 1111×2, 0111×5, then wraps to 1110. `tick` fires 4 times per 28 cycles.
- **Descending scan:** `dir`=1 from reset → digit order 0, 3, 2, 1, 0 (`anode` 1110, 0111, 1011, 1101); `digit_idx` wraps 0→3.
- **Sparse mask:** `mask`=0101 → only 1110 and 1011 alternate; period 14 cycles; digits 1 and 3 are never active.
- **Empty mask, then single digit:** `mask`=0000 → `anode` stays 1111, `blank`=1, `tick` never fires. Then `mask`=0010 → `anode`=1101 within 2 blank cycles and repeats every 7 cycles.
- **Enable drop:** `en`=0 on the 3rd DRIVE cycle of digit 1 → `anode`=1111 the next cycle and holds. Re-assert `en` → 2 blank cycles, then digit 2 is active for 5 cycles.
- **Mid-operation events:**
  - `reset` in mid-DRIVE → next cycle `anode`=1111, `tick`=0, `digit_idx`=0; digit 0 is active after 2 blank cycles.
  - Clearing the current digit's mask bit mid-DRIVE → that digit goes dark the next cycle.
